y_signature_capture: RTL and testbench

- Downstream consumer of the 82-bit `y` result bus of the fuzz DUT top.
- After each new stimulus vector, waits a programmable settle window, then folds `y` into a multiple-input signature register (MISR).
- Produces one compact signature per run, so runs under different simulators can be compared by a single word.
- Sits between the DUT output and the testbench's result checker.

---
 rtl/y_signature_capture.sv | 110 +++++++++++
 tb/tb_y_signature_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y_signature_capture.sv
// Folds the 82-bit DUT result bus into a MISR once per stimulus vector, after a
// programmable settle window, yielding one comparable signature per run.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// WAIT   | run active, waiting for sample_en
// SETTLE | counting down the settle window
// SAMPLE | folding y_in into the signature this cycle
// DONE   | run complete, signature final until start
module y_signature_capture #(
  parameter int              WIDTH         = 82,
  parameter int              SETTLE_CYCLES = 2,
  parameter int              NUM_SAMPLES   = 256,
  parameter logic [WIDTH-1:0] POLY         = WIDTH'(3),
  parameter logic [WIDTH-1:0] SEED         = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      sample_count,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [7:0]  LP_SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [15:0] LP_NUM    = 16'(NUM_SAMPLES);

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_sig;
  logic [15:0]        r_count;
  logic               r_overrun;
  logic [7:0]         r_settle;
  logic [WIDTH-1:0]   w_fold;
  logic [15:0]        w_count_inc;
  logic               w_last;

  assign w_fold      = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ y_in;
  assign w_count_inc = r_count + 16'd1;
  assign w_last      = (w_count_inc == LP_NUM);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_WAIT;
      S_WAIT:         if (sample_en) w_next = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
      S_SETTLE:       if (r_settle <= 8'd1) w_next = S_SAMPLE;
      S_SAMPLE:       w_next = w_last ? S_DONE : S_WAIT;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_WAIT, S_SETTLE, S_SAMPLE: busy = 1'b1;
      S_DONE:                     done = 1'b1;
      default: ;
    endcase
  end

  // Overrun only flags pulses lost mid-vector; pulses in IDLE/DONE are simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig     <= SEED;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_settle  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_sig     <= SEED;
            r_count   <= '0;
            r_overrun <= 1'b0;
          end
        end
        S_WAIT: begin
          if (sample_en) r_settle <= LP_SETTLE;
        end
        S_SETTLE: begin
          r_settle <= r_settle - 8'd1;
          if (sample_en) r_overrun <= 1'b1;
        end
        S_SAMPLE: begin
          r_sig   <= w_fold;
          r_count <= w_count_inc;
          if (sample_en) r_overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign signature    = r_sig;
  assign sample_count = r_count;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_y_signature_capture.sv
// Three differently-parameterised captures share one stimulus stream and are
// checked every cycle against a transaction-level model of a capture run.
module tb_y_signature_capture;

  localparam int W = 82;
  localparam logic [W-1:0] POLY   = 82'h3;
  localparam logic [W-1:0] SEED_C = {1'b1, 81'b0};

  logic         clk = 1'b0;
  logic         rst, start, sample_en;
  logic [W-1:0] y_in;

  logic [W-1:0] sig_a, sig_b, sig_c;
  logic [15:0]  cnt_a, cnt_b, cnt_c;
  logic         busy_a, busy_b, busy_c, done_a, done_b, done_c, ov_a, ov_b, ov_c;

  always #5 clk = ~clk;

  y_signature_capture #(.WIDTH(W), .SETTLE_CYCLES(2), .NUM_SAMPLES(4), .POLY(POLY), .SEED('0)) u_a (
    .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .y_in(y_in),
    .signature(sig_a), .sample_count(cnt_a), .busy(busy_a), .done(done_a), .overrun(ov_a));

  y_signature_capture #(.WIDTH(W), .SETTLE_CYCLES(0), .NUM_SAMPLES(2), .POLY(POLY), .SEED('0)) u_b (
    .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .y_in(y_in),
    .signature(sig_b), .sample_count(cnt_b), .busy(busy_b), .done(done_b), .overrun(ov_b));

  y_signature_capture #(.WIDTH(W), .SETTLE_CYCLES(1), .NUM_SAMPLES(1), .POLY(POLY), .SEED(SEED_C)) u_c (
    .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .y_in(y_in),
    .signature(sig_c), .sample_count(cnt_c), .busy(busy_c), .done(done_c), .overrun(ov_c));

  // A run is "running" from start until the last fold; a vector is "pending"
  // from its accepted sample_en until its fold, which is due S+1 edges later.
  typedef struct {
    logic [W-1:0] sig;
    int           cnt;
    bit           ov;
    bit           done;
    bit           running;
    bit           pending;
    int           due;
  } m_t;

  m_t ma, mb, mc;
  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;
  bit chk_on = 1'b0;

  function automatic m_t m_step(input m_t m, input int now, input int s, input int n,
                                input logic [W-1:0] seed, input bit r, input bit st,
                                input bit en, input logic [W-1:0] y);
    m_t           q;
    logic [W:0]   sh;
    q = m;
    if (r) begin
      q.sig = seed; q.cnt = 0; q.ov = 0; q.done = 0; q.running = 0; q.pending = 0; q.due = 0;
    end else if (!q.running) begin
      if (st) begin
        q.sig = seed; q.cnt = 0; q.ov = 0; q.done = 0; q.running = 1; q.pending = 0;
      end
    end else if (q.pending) begin
      if (en) q.ov = 1;
      if (now == q.due) begin
        sh    = {q.sig, 1'b0};
        q.sig = sh[W-1:0] ^ (sh[W] ? POLY : '0) ^ y;
        q.cnt = q.cnt + 1;
        q.pending = 0;
        if (q.cnt == n) begin
          q.running = 0;
          q.done    = 1;
        end
      end
    end else if (en) begin
      q.pending = 1;
      q.due     = now + s + 1;
    end
    return q;
  endfunction

  always @(posedge clk) begin
    ma  <= m_step(ma, cyc, 2, 4, '0, rst, start, sample_en, y_in);
    mb  <= m_step(mb, cyc, 0, 2, '0, rst, start, sample_en, y_in);
    mc  <= m_step(mc, cyc, 1, 1, SEED_C, rst, start, sample_en, y_in);
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input m_t m, input logic [W-1:0] sig, input logic [15:0] cnt,
                     input logic bsy, input logic dn, input logic ov);
    chk({tag, "_sig"},  sig,        m.sig);
    chk({tag, "_cnt"},  W'(cnt),    W'(m.cnt));
    chk({tag, "_busy"}, W'(bsy),    W'(m.running));
    chk({tag, "_done"}, W'(dn),     W'(m.done));
    chk({tag, "_ovr"},  W'(ov),     W'(m.ov));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("a", ma, sig_a, cnt_a, busy_a, done_a, ov_a);
      cmp("b", mb, sig_b, cnt_b, busy_b, done_b, ov_b);
      cmp("c", mc, sig_c, cnt_c, busy_c, done_c, ov_c);
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_en();
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [95:0] r96;
    rst = 1'b1; start = 1'b0; sample_en = 1'b0; y_in = '0;
    ticks(2);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_a_sig", sig_a, '0);
    chk("rst_c_sig", sig_c, SEED_C);
    chk("rst_a_cnt", W'(cnt_a), '0);
    chk("rst_a_busy", W'(busy_a), '0);
    chk("rst_a_done", W'(done_a), '0);

    pulse_en();
    chk("idle_en_busy", W'(busy_a), '0);
    chk("idle_en_ovr", W'(ov_a), '0);

    do_start();
    chk("start_busy", W'(busy_a), W'(1));

    y_in = W'(1);
    pulse_en();
    ticks(1);
    chk("b_fold1_sig", sig_b, W'(1));
    chk("b_fold1_cnt", W'(cnt_b), W'(1));
    chk("a_lat_e2", W'(cnt_a), '0);
    y_in = '0;
    ticks(1);
    chk("c_msb_sig", sig_c, W'(3));
    chk("c_done", W'(done_c), W'(1));
    chk("c_busy", W'(busy_c), '0);
    chk("a_lat_e3", W'(cnt_a), '0);
    ticks(1);
    chk("a_lat_e4", W'(cnt_a), W'(1));

    pulse_en();
    ticks(1);
    chk("b_fold2_sig", sig_b, W'(2));
    chk("b_done", W'(done_b), W'(1));
    chk("b_busy", W'(busy_b), '0);
    chk("c_done_en_ovr", W'(ov_c), '0);
    ticks(3);

    pulse_en();
    pulse_en();
    ticks(4);
    chk("a_ovr", W'(ov_a), W'(1));
    chk("a_ovr_cnt", W'(cnt_a), W'(3));
    chk("b_done_en_ovr", W'(ov_b), '0);

    do_start();
    chk("a_wait_start_cnt", W'(cnt_a), W'(3));
    chk("a_wait_start_ovr", W'(ov_a), W'(1));
    chk("a_wait_start_busy", W'(busy_a), W'(1));
    chk("b_restart_sig", sig_b, '0);
    chk("b_restart_done", W'(done_b), '0);
    chk("b_restart_busy", W'(busy_b), W'(1));
    chk("c_restart_sig", sig_c, SEED_C);

    pulse_en();
    chk("a_settle_cnt", W'(cnt_a), W'(3));
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    chk("midrst_sig", sig_a, '0);
    chk("midrst_cnt", W'(cnt_a), '0);
    chk("midrst_busy", W'(busy_a), '0);
    chk("midrst_ovr", W'(ov_a), '0);
    pulse_en();
    ticks(4);
    chk("postrst_cnt", W'(cnt_a), '0);
    chk("postrst_busy", W'(busy_a), '0);

    do_start();
    for (int k = 0; k < 4; k++) begin
      pulse_en();
      ticks(2);
      chk("run_pre", W'(cnt_a), W'(k));
      ticks(1);
      chk("run_post", W'(cnt_a), W'(k + 1));
      ticks(6);
    end
    chk("run_sig", sig_a, '0);
    chk("run_cnt", W'(cnt_a), W'(4));
    chk("run_done", W'(done_a), W'(1));
    chk("run_busy", W'(busy_a), '0);

    do_start();
    pulse_en();
    pulse_en();
    ticks(3);
    for (int k = 0; k < 3; k++) begin
      pulse_en();
      ticks(4);
    end
    chk("ovr_done", W'(done_a), W'(1));
    chk("ovr_sticky", W'(ov_a), W'(1));
    do_start();
    chk("ovr_clear", W'(ov_a), '0);
    chk("ovr_clear_done", W'(done_a), '0);
    chk("ovr_clear_busy", W'(busy_a), W'(1));

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 15) == 0);
      sample_en = ($urandom_range(0, 3) == 0);
      r96       = {$urandom, $urandom, $urandom};
      y_in      = r96[W-1:0];
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; sample_en = 1'b0;
    ticks(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
